// File: rtl/demux4_stage.sv
// Registered 1-to-4 dispatch stage: one valid/ready producer fans out to four
// valid/ready consumers through a single holding register, with per-port transfer counters.
module demux4_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    output logic                  out0_valid,
    output logic                  out1_valid,
    output logic                  out2_valid,
    output logic                  out3_valid,
    input  logic                  out0_ready,
    input  logic                  out1_ready,
    input  logic                  out2_ready,
    input  logic                  out3_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic [DATA_WIDTH-1:0] out3_data,
    output logic [7:0]            count0,
    output logic [7:0]            count1,
    output logic [7:0]            count2,
    output logic [7:0]            count3
);

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned CNT_WIDTH = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [1:0]                             r_sel;
    logic [DATA_WIDTH-1:0]                  r_data;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]    r_count;

    logic [NUM_PORTS-1:0] w_out_ready;
    logic [NUM_PORTS-1:0] w_out_valid;
    logic                 w_sel_ready;
    logic                 w_xfer;
    logic                 w_accept;

    assign w_out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};
    assign w_sel_ready = w_out_ready[r_sel];
    assign w_xfer      = (r_state == ST_FULL) && w_sel_ready;
    // Readiness looks through to the selected consumer so a draining word frees the slot in the same cycle.
    assign in_ready    = (r_state == ST_EMPTY) || w_sel_ready;
    assign w_accept    = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_xfer && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= 2'd0;
            r_data <= '0;
        end else if (w_accept) begin
            r_sel  <= in_sel;
            r_data <= in_data;
        end
    end

    // Counter of the outgoing destination bumps on the transfer edge, independent of any new accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count[r_sel] <= r_count[r_sel] + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_out_valid = '0;
        w_out_valid[r_sel] = (r_state == ST_FULL);
    end

    assign out0_valid = w_out_valid[0];
    assign out1_valid = w_out_valid[1];
    assign out2_valid = w_out_valid[2];
    assign out3_valid = w_out_valid[3];

    assign out0_data = w_out_valid[0] ? r_data : '0;
    assign out1_data = w_out_valid[1] ? r_data : '0;
    assign out2_data = w_out_valid[2] ? r_data : '0;
    assign out3_data = w_out_valid[3] ? r_data : '0;

    assign count0 = r_count[0];
    assign count1 = r_count[1];
    assign count2 = r_count[2];
    assign count3 = r_count[3];

endmodule

// File: tb/tb_demux4_stage.sv
// Bench for demux4_stage: vector table for streaming, scoreboard for routed
// payloads, hand-written sequences for back-pressure, counter wrap and async reset.
module tb_demux4_stage;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic [3:0]    rdy;
    logic          out0_valid, out1_valid, out2_valid, out3_valid;
    logic [DW-1:0] out0_data, out1_data, out2_data, out3_data;
    logic [7:0]    count0, count1, count2, count3;

    logic [3:0]         w_valid;
    logic [3:0][DW-1:0] w_data;
    logic [3:0][7:0]    w_count;

    assign w_valid = {out3_valid, out2_valid, out1_valid, out0_valid};
    assign w_data  = {out3_data, out2_data, out1_data, out0_data};
    assign w_count = {count3, count2, count1, count0};

    demux4_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out0_valid(out0_valid), .out1_valid(out1_valid),
        .out2_valid(out2_valid), .out3_valid(out3_valid),
        .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]), .out3_ready(rdy[3]),
        .out0_data(out0_data), .out1_data(out1_data),
        .out2_data(out2_data), .out3_data(out3_data),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic          vld;
        logic [1:0]    sel;
        logic [DW-1:0] data;
        logic [3:0]    rdy;
        logic          exp_in_ready;
        logic [3:0]    exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Negedge sample: pop/compare transfers about to happen, then record an accept about to happen.
    task automatic sample();
        logic [DW-1:0] nonsel;
        sb_t           item;
        @(negedge clk);
        nonsel = '0;
        for (int n = 0; n < 4; n++) begin
            if (!w_valid[n]) nonsel = nonsel | w_data[n];
            if (w_valid[n] && rdy[n]) begin
                if (sb.size() == 0) begin
                    check($sformatf("sb_empty_port%0d", n), w_data[n], 32'hx);
                end else begin
                    item = sb.pop_front();
                    check($sformatf("sb_port%0d", n), 32'(n), 32'(item.sel));
                    check($sformatf("sb_data%0d", n), w_data[n], item.data);
                end
            end
        end
        check("nonsel_data_zero", nonsel, '0);
        check("valid_onehot0", 32'($countones(w_valid) <= 1), 32'd1);
        if (in_valid && in_ready) sb.push_back('{in_sel, in_data});
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_data  = '0;
        rdy      = 4'h0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        advance();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_valid"}, 32'(w_valid), 32'd0);
        check({tag, "_data_or"}, w_data[0] | w_data[1] | w_data[2] | w_data[3], '0);
        check({tag, "_counts"}, w_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 2'd0, 32'hA000_0000, 4'hF, 1'b1, 4'b0000, 32'h0};
        vecs[1] = '{1'b1, 2'd1, 32'hA111_1111, 4'hF, 1'b1, 4'b0001, 32'hA000_0000};
        vecs[2] = '{1'b1, 2'd2, 32'hA222_2222, 4'hF, 1'b1, 4'b0010, 32'hA111_1111};
        vecs[3] = '{1'b1, 2'd3, 32'hA333_3333, 4'hF, 1'b1, 4'b0100, 32'hA222_2222};
        vecs[4] = '{1'b1, 2'd0, 32'hA444_4444, 4'hF, 1'b1, 4'b1000, 32'hA333_3333};
        vecs[5] = '{1'b0, 2'd3, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'b0001, 32'hA444_4444};
        vecs[6] = '{1'b0, 2'd1, 32'h0,         4'hF, 1'b1, 4'b0000, 32'h0};

        rst = 1'b0;
        do_reset();
        #2;
        check_idle("reset");

        // Streaming across all destinations, one word per cycle.
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].vld;
            in_sel   = vecs[i].sel;
            in_data  = vecs[i].data;
            rdy      = vecs[i].rdy;
            sample();
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_valid", i), 32'(w_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), w_data[0] | w_data[1] | w_data[2] | w_data[3],
                  vecs[i].exp_data);
            advance();
        end
        check("stream_counts", w_count, {8'd1, 8'd1, 8'd1, 8'd2});

        // Single routed word to port 2.
        do_reset();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEAD_BEEF; rdy = 4'b0100;
        cycle();
        in_valid = 1'b0; in_data = '0;
        sample();
        check("single_valid", 32'(w_valid), 32'b0100);
        check("single_data", out2_data, 32'hDEAD_BEEF);
        check("single_cnt_before", 32'(count2), 32'd0);
        advance();
        sample();
        check("single_cnt_after", 32'(count2), 32'd1);
        check("single_drained", 32'(w_valid), 32'd0);
        advance();

        // Back-pressure on port 1, then simultaneous transfer and accept.
        do_reset();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11; rdy = 4'h0;
        cycle();
        in_data = 32'h22;
        for (int c = 0; c < 5; c++) begin
            sample();
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_valid", c), 32'(out1_valid), 32'd1);
            check($sformatf("bp%0d_data", c), out1_data, 32'h11);
            advance();
        end
        rdy = 4'b0010;
        sample();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_data", out1_data, 32'h11);
        advance();
        in_valid = 1'b0; in_data = '0;
        sample();
        check("bp_next_data", out1_data, 32'h22);
        check("bp_cnt_mid", 32'(count1), 32'd1);
        advance();
        sample();
        check("bp_cnt_end", 32'(count1), 32'd2);
        advance();

        // Ready on a non-selected port must not release the held word.
        do_reset();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h5A5A; rdy = 4'b1110;
        cycle();
        in_valid = 1'b0;
        cycle();
        sample();
        check("nonsel_rdy_hold", 32'(out0_valid), 32'd1);
        check("nonsel_rdy_cnt", w_count, 32'd0);
        advance();

        // Async reset mid-operation discards the held word.
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_valid", 32'(out0_valid), 32'd0);
        check("async_rst_data", out0_data, '0);
        check("async_rst_cnt", 32'(count0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy = 4'hF;
        advance();
        cycle();
        check_idle("post_rst");

        // Counter wrap on port 3.
        do_reset();
        rdy = 4'hF; in_valid = 1'b1; in_sel = 2'd3;
        for (int k = 0; k < 256; k++) begin
            in_data = 32'h3000_0000 + 32'(k);
            cycle();
        end
        in_valid = 1'b0;
        sample();
        check("wrap_cnt_255", 32'(count3), 32'd255);
        advance();
        sample();
        check("wrap_cnt_0", 32'(count3), 32'd0);
        check("wrap_others", {8'd0, count2, count1, count0}, 32'd0);
        advance();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
